// File: rtl/switch_pkg.sv
// Shared switch constants and the one-hot destination decode used by the side logic.
package switch_pkg;

    localparam int NPORTS = 4;
    localparam int ADRW   = 2;

    function automatic logic [NPORTS-1:0] onehot4(input logic [ADRW-1:0] idx);
        logic [NPORTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/side_arbiter_if.sv
// Transmit-port handshakes plus the internal transfer bus toward the opposite side's FIFOs.
interface side_arbiter_if
    import switch_pkg::*;
#(
    parameter int DW = 4
);

    logic [NPORTS-1:0]           validtx;
    logic [NPORTS-1:0][ADRW-1:0] adr_i;
    logic [NPORTS-1:0][DW-1:0]   dat_i;
    logic [NPORTS-1:0]           full_i;
    logic [NPORTS-1:0]           acktx;
    logic [NPORTS-1:0]           int_wen_o;
    logic [DW-1:0]               int_dat_o;
    logic                        gnt_vld_o;
    logic [ADRW-1:0]             gnt_idx_o;

    modport master (
        output validtx, adr_i, dat_i, full_i,
        input  acktx, int_wen_o, int_dat_o, gnt_vld_o, gnt_idx_o
    );

    modport slave (
        input  validtx, adr_i, dat_i, full_i,
        output acktx, int_wen_o, int_dat_o, gnt_vld_o, gnt_idx_o
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first set request at or after ptr wins.
module rr_pick4
    import switch_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic [ADRW-1:0]   ptr,
    output logic [NPORTS-1:0] gnt,
    output logic [ADRW-1:0]   idx,
    output logic              any
);

    logic [NPORTS-1:0] rot;
    logic [ADRW-1:0]   off;

    // rot[k] is the request k positions after ptr; the 2-bit index wraps mod 4
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_rot
            assign rot[gi] = req[ptr + ADRW'(gi)];
        end
    endgenerate

    always_comb begin
        off = '0;
        any = 1'b0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = ADRW'(k);
                any = 1'b1;
            end
        end
    end

    assign idx = ptr + off;
    assign gnt = any ? onehot4(idx) : '0;

endmodule

// File: rtl/side_arbiter.sv
// Round-robin arbiter sharing one internal transfer bus among four transmit ports.
module side_arbiter
    import switch_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    side_arbiter_if.slave bus
);

    logic [NPORTS-1:0] elig;
    logic [NPORTS-1:0] pick_gnt;
    logic [ADRW-1:0]   pick_idx;
    logic              pick_any;

    logic [ADRW-1:0]   ptr_reg, ptr_next;
    logic [NPORTS-1:0] wen_reg, wen_next;
    logic [NPORTS-1:0] ack_reg, ack_next;
    logic [DW-1:0]     dat_reg, dat_next;
    logic              vld_reg, vld_next;
    logic [ADRW-1:0]   idx_reg, idx_next;

    // The registered write enable and ack double as dst_mask and ack_mask: they
    // block the same destination and the same port for the cycle after a grant.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_elig
            assign elig[gi] = bus.validtx[gi]
                            & ~bus.full_i[bus.adr_i[gi]]
                            & ~ack_reg[gi]
                            & ~wen_reg[bus.adr_i[gi]];
        end
    endgenerate

    rr_pick4 u_pick (
        .req (elig),
        .ptr (ptr_reg),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        ptr_next = ptr_reg;
        wen_next = '0;
        ack_next = '0;
        dat_next = '0;
        vld_next = 1'b0;
        idx_next = '0;
        if (pick_any) begin
            ptr_next = pick_idx + ADRW'(1);
            wen_next = onehot4(bus.adr_i[pick_idx]);
            ack_next = pick_gnt;
            dat_next = bus.dat_i[pick_idx];
            vld_next = 1'b1;
            idx_next = pick_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg <= '0;
            wen_reg <= '0;
            ack_reg <= '0;
            dat_reg <= '0;
            vld_reg <= 1'b0;
            idx_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
            wen_reg <= wen_next;
            ack_reg <= ack_next;
            dat_reg <= dat_next;
            vld_reg <= vld_next;
            idx_reg <= idx_next;
        end
    end

    assign bus.int_wen_o = wen_reg;
    assign bus.acktx     = ack_reg;
    assign bus.int_dat_o = dat_reg;
    assign bus.gnt_vld_o = vld_reg;
    assign bus.gnt_idx_o = idx_reg;

endmodule
